// File: rtl/pkt_chan_pkg.sv
// Shared definitions for the packet channel: state encoding and default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pkt_chan_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int LEN_W_DEFAULT  = 4;

  // Encoding is shared with the downstream channel FSM; keep values fixed.
  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_HEAD = 2'b01,
    STATE_DATA = 2'b10,
    STATE_TAIL = 2'b11
  } state_e;

endpackage

// File: rtl/pkt_out_reg.sv
// Output holding register for one framed beat (valid/head/tail/data).
// Latency: 1 cycle from load_i to valid_o.
// Backpressure: contents held while valid_o & ~accept_i; accept without load clears the beat.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   load_i              capture ld_head_i/ld_tail_i/ld_data_i and set valid
//   ld_head_i/ld_tail_i beat markers for the word being loaded
//   ld_data_i           payload word being loaded
//   accept_i            downstream ready
//   valid_o/head_o/tail_o/data_o  registered beat
module pkt_out_reg #(
  parameter int DATA_W = pkt_chan_pkg::DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              ld_head_i,
  input  logic              ld_tail_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              accept_i,
  output logic              valid_o,
  output logic              head_o,
  output logic              tail_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic              head_q;
  logic              tail_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      head_q  <= ld_head_i;
      tail_q  <= ld_tail_i;
      data_q  <= ld_data_i;
    end else if (valid_q && accept_i) begin
      // Data is left as-is; only the qualifiers drop.
      valid_q <= 1'b0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pkt_framer.sv
// Packet framer: takes a length request, pulls that many source words, emits head/data/tail beats.
// Latency: request to first valid beat 2 cycles; 1 word/cycle steady state.
// Backpressure: valid/ready output, beat held while stalled; source is stalled through src_ready.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   req_valid/req_len/req_ready      packet request (length in words)
//   src_valid/src_data/src_ready     payload source stream
//   valid/head/tail/data/out_ready   framed output stream
//   len_err                          one-cycle pulse when a zero-length request is dropped
//   pkt_count                        accepted-tail counter, present only with PKT_FRAMER_STATS_EN
module pkt_framer
  import pkt_chan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              valid,
  output logic              head,
  output logic              tail,
  output logic [DATA_W-1:0] data,
  input  logic              out_ready,
  output logic              len_err
`ifdef PKT_FRAMER_STATS_EN
  ,
  output logic [15:0]       pkt_count
`endif
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               len_err_q, len_err_d;
  logic               src_fire;
  logic               last_word;

  assign last_word = (rem_q == LEN_W'(1));
  assign src_fire  = src_valid && src_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= STATE_IDLE;
      rem_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_err_d = 1'b0;
    req_ready = (state_q == STATE_IDLE);
    // Only HEAD/DATA pull words: in TAIL the counter is already zero and the
    // tail beat is still draining, so no further word may be consumed.
    src_ready = ((state_q == STATE_HEAD) || (state_q == STATE_DATA)) &&
                (!valid || out_ready);

    unique case (state_q)
      STATE_IDLE: begin
        if (req_valid) begin
          if (req_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            rem_d   = req_len;
            state_d = STATE_HEAD;
          end
        end
      end
      STATE_HEAD, STATE_DATA: begin
        if (src_fire) begin
          rem_d   = rem_q - LEN_W'(1);
          state_d = last_word ? STATE_TAIL : STATE_DATA;
        end
      end
      STATE_TAIL: begin
        if (valid && out_ready) begin
          state_d = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  pkt_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (src_fire),
    .ld_head_i (state_q == STATE_HEAD),
    .ld_tail_i (last_word),
    .ld_data_i (src_data),
    .accept_i  (out_ready),
    .valid_o   (valid),
    .head_o    (head),
    .tail_o    (tail),
    .data_o    (data)
  );

  assign len_err = len_err_q;

`ifdef PKT_FRAMER_STATS_EN
  logic [15:0] pkt_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else if (valid && tail && out_ready) begin
      pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_pkt_framer.sv
// Self-checking bench for pkt_framer: cycle table plus hand-written corner sequences.
module tb_pkt_framer;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              req_ready;
  logic              src_valid = 1'b0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_ready;
  logic              valid;
  logic              head;
  logic              tail;
  logic [DATA_W-1:0] data;
  logic              out_ready = 1'b1;
  logic              len_err;
`ifdef PKT_FRAMER_STATS_EN
  logic [15:0]       pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .valid     (valid),
    .head      (head),
    .tail      (tail),
    .data      (data),
    .out_ready (out_ready),
    .len_err   (len_err)
`ifdef PKT_FRAMER_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  typedef struct {
    logic              rst;
    logic              rv;
    logic [LEN_W-1:0]  rl;
    logic              sv;
    logic [DATA_W-1:0] sd;
    logic              ordy;
    logic              e_rrdy;
    logic              e_srdy;
    logic              e_v;
    logic              e_h;
    logic              e_t;
    logic [DATA_W-1:0] e_d;
    logic              e_le;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rv, input logic [LEN_W-1:0] rl,
                     input logic sv, input logic [DATA_W-1:0] sd, input logic ordy,
                     input logic rrdy, input logic srdy, input logic v, input logic h,
                     input logic t, input logic [DATA_W-1:0] d, input logic le);
    vec_t x;
    x = '{rst, rv, rl, sv, sd, ordy, rrdy, srdy, v, h, t, d, le};
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n_sent;
    int n_beats;

    // rst rv rl sv sd ordy | rrdy srdy v h t d le
    // reset
    add(1,0,0, 0,8'h00,1, 1,0,0,0,0,8'h00,0);            // 0
    // len 3: A1 A2 A3 back to back
    add(0,1,3, 0,8'h00,1, 1,0,0,0,0,8'h00,0);            // 1
    add(0,0,0, 1,8'hA1,1, 0,1,0,0,0,8'h00,0);            // 2
    add(0,0,0, 1,8'hA2,1, 0,1,1,1,0,8'hA1,0);            // 3
    add(0,0,0, 1,8'hA3,1, 0,1,1,0,0,8'hA2,0);            // 4
    add(0,0,0, 0,8'h00,1, 0,0,1,0,1,8'hA3,0);            // 5
    add(0,0,0, 0,8'h00,1, 1,0,0,0,0,8'hA3,0);            // 6
    // len 1: head and tail on the same beat
    add(0,1,1, 0,8'h00,1, 1,0,0,0,0,8'hA3,0);            // 7
    add(0,0,0, 1,8'h5A,1, 0,1,0,0,0,8'hA3,0);            // 8
    add(0,0,0, 0,8'h00,1, 0,0,1,1,1,8'h5A,0);            // 9
    add(0,0,0, 0,8'h00,1, 1,0,0,0,0,8'h5A,0);            // 10
    // len 0 dropped with len_err, then len 2
    add(0,1,0, 0,8'h00,1, 1,0,0,0,0,8'h5A,0);            // 11
    add(0,1,2, 0,8'h00,1, 1,0,0,0,0,8'h5A,1);            // 12
    add(0,0,0, 1,8'hB1,1, 0,1,0,0,0,8'h5A,0);            // 13
    add(0,0,0, 1,8'hB2,1, 0,1,1,1,0,8'hB1,0);            // 14
    add(0,0,0, 0,8'h00,1, 0,0,1,0,1,8'hB2,0);            // 15
    add(0,0,0, 0,8'h00,1, 1,0,0,0,0,8'hB2,0);            // 16
    // len 4: 3-cycle stall on beat 2, then a source bubble
    add(0,1,4, 0,8'h00,1, 1,0,0,0,0,8'hB2,0);            // 17
    add(0,0,0, 1,8'hC1,1, 0,1,0,0,0,8'hB2,0);            // 18
    add(0,0,0, 1,8'hC2,1, 0,1,1,1,0,8'hC1,0);            // 19
    add(0,0,0, 1,8'hC3,0, 0,0,1,0,0,8'hC2,0);            // 20
    add(0,0,0, 1,8'hC3,0, 0,0,1,0,0,8'hC2,0);            // 21
    add(0,0,0, 1,8'hC3,0, 0,0,1,0,0,8'hC2,0);            // 22
    add(0,0,0, 1,8'hC3,1, 0,1,1,0,0,8'hC2,0);            // 23
    add(0,0,0, 0,8'h00,1, 0,1,1,0,0,8'hC3,0);            // 24
    add(0,0,0, 1,8'hC4,1, 0,1,0,0,0,8'hC3,0);            // 25
    add(0,0,0, 0,8'h00,0, 0,0,1,0,1,8'hC4,0);            // 26
    add(0,0,0, 0,8'h00,1, 0,0,1,0,1,8'hC4,0);            // 27
    add(0,0,0, 0,8'h00,1, 1,0,0,0,0,8'hC4,0);            // 28

    foreach (vecs[i]) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      req_valid = vecs[i].rv;
      req_len   = vecs[i].rl;
      src_valid = vecs[i].sv;
      src_data  = vecs[i].sd;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d {rrdy,srdy,v,h,t,le,d}", i),
            {18'd0, req_ready, src_ready, valid, head, tail, len_err, data},
            {18'd0, vecs[i].e_rrdy, vecs[i].e_srdy, vecs[i].e_v, vecs[i].e_h,
             vecs[i].e_t, vecs[i].e_le, vecs[i].e_d});
    end

    // Maximum length packet with the source always offering words:
    // exactly 15 words consumed and framed, nothing extra pulled in TAIL.
    @(negedge clk);
    req_valid = 1'b1; req_len = 4'd15; src_valid = 1'b0; out_ready = 1'b1;
    n_sent = 0; n_beats = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      src_valid = 1'b1;
      src_data  = 8'h10 + 8'(n_sent);
      #1;
      if (valid) begin
        check($sformatf("max beat%0d {h,t,d}", n_beats),
              {22'd0, head, tail, data},
              {22'd0, (n_beats == 0), (n_beats == 14), 8'h10 + 8'(n_beats)});
        n_beats++;
      end
      if (src_valid && src_ready) n_sent++;
    end
    check("max beats", n_beats, 15);
    check("max words consumed", n_sent, 15);
    check("max req_ready after", {31'd0, req_ready}, 1);
    @(negedge clk);
    src_valid = 1'b0;

`ifdef PKT_FRAMER_STATS_EN
    #1;
    check("pkt_count before reset", {16'd0, pkt_count}, 5);
`endif

    // Reset in the middle of a 5-word packet, then a clean 2-word packet.
    @(negedge clk);
    req_valid = 1'b1; req_len = 4'd5;
    @(negedge clk);
    req_valid = 1'b0; src_valid = 1'b1; src_data = 8'hD1;
    @(negedge clk);
    src_data = 8'hD2;
    #1;
    check("rst seq beat1 {v,h,t,d}", {21'd0, valid, head, tail, data}, {21'd0, 1'b1, 1'b1, 1'b0, 8'hD1});
    @(negedge clk);
    src_data = 8'hD3;
    #1;
    check("rst seq beat2 {v,h,t,d}", {21'd0, valid, head, tail, data}, {21'd0, 1'b1, 1'b0, 1'b0, 8'hD2});
    reset = 1'b1;
    #1;
    check("rst async {v,h,t,d,rrdy,srdy}", {18'd0, valid, head, tail, data, req_ready, src_ready},
          {18'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0; src_valid = 1'b0; req_valid = 1'b1; req_len = 4'd2;
    @(negedge clk);
    req_valid = 1'b0; src_valid = 1'b1; src_data = 8'hE1;
    @(negedge clk);
    src_data = 8'hE2;
    #1;
    check("post rst head {v,h,t,d}", {21'd0, valid, head, tail, data}, {21'd0, 1'b1, 1'b1, 1'b0, 8'hE1});
    @(negedge clk);
    src_valid = 1'b0;
    #1;
    check("post rst tail {v,h,t,d}", {21'd0, valid, head, tail, data}, {21'd0, 1'b1, 1'b0, 1'b1, 8'hE2});
    @(negedge clk);
    #1;
    check("post rst idle {v,rrdy}", {30'd0, valid, req_ready}, {30'd0, 1'b0, 1'b1});

`ifdef PKT_FRAMER_STATS_EN
    check("pkt_count after reset", {16'd0, pkt_count}, 1);
    @(negedge clk);
    force dut.pkt_count_q = 16'hFFFF;
    #1;
    release dut.pkt_count_q;
    #1;
    check("pkt_count preload", {16'd0, pkt_count}, 32'h0000FFFF);
    req_valid = 1'b1; req_len = 4'd1;
    @(negedge clk);
    req_valid = 1'b0; src_valid = 1'b1; src_data = 8'h77;
    @(negedge clk);
    src_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pkt_count wrap", {16'd0, pkt_count}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
